// File: rtl/bip_sequencer.sv
// bip_sequencer: fetch/execute control sequencer for a basic instruction processor.
// Two cycles per instruction minimum; control strobes are only live in EXECUTE.
module bip_sequencer #(
  parameter int NB_ADDR       = 11,
  parameter int NB_OPCODE     = 5,
  parameter int NB_OPERAND    = 11,
  parameter int NB_SELECTOR_A = 2,
  parameter int NB_COUNT      = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  output logic                     o_fetch_req,
  input  logic                     i_instr_valid,
  input  logic [NB_OPCODE-1:0]     i_opcode,
  input  logic [NB_OPERAND-1:0]    i_operand,
  input  logic                     i_acc_zero,
  input  logic                     i_acc_neg,
  output logic [NB_ADDR-1:0]       o_address,
  output logic [NB_OPERAND-1:0]    o_operand,
  output logic [NB_SELECTOR_A-1:0] o_sel_a,
  output logic                     o_sel_b,
  output logic                     o_enb_acc,
  output logic                     o_operation,
  output logic                     o_wr_enb_ram,
  output logic                     o_rd_enb_ram,
  output logic                     o_program_done,
  output logic [NB_COUNT-1:0]      o_instr_count
);
  typedef enum logic [1:0] {IDLE, FETCH, EXECUTE, HALT} state_t;
  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);
  localparam logic [NB_OPCODE-1:0] OP_JMP  = NB_OPCODE'(8);
  localparam logic [NB_OPCODE-1:0] OP_BEQ  = NB_OPCODE'(9);
  localparam logic [NB_OPCODE-1:0] OP_BNE  = NB_OPCODE'(10);
  localparam logic [NB_OPCODE-1:0] OP_BLT  = NB_OPCODE'(11);
  state_t state, state_next;
  logic [NB_ADDR-1:0] pc, pc_next;
  logic [NB_OPCODE-1:0] opcode;
  logic [NB_OPERAND-1:0] operand;
  logic [NB_COUNT-1:0] count;
  logic exec, arith, taken;
  assign exec  = state == EXECUTE;
  assign arith = opcode >= OP_ADD && opcode <= OP_SUBI;
  assign taken = opcode == OP_JMP || (opcode == OP_BEQ && i_acc_zero) ||
                 (opcode == OP_BNE && !i_acc_zero) || (opcode == OP_BLT && i_acc_neg);
  assign o_fetch_req    = state == FETCH;
  assign o_program_done = state == HALT;
  assign o_address      = pc;
  assign o_operand      = operand;
  assign o_instr_count  = count;
  assign o_wr_enb_ram   = exec && opcode == OP_STO;
  assign o_rd_enb_ram   = exec && (opcode == OP_LD || opcode == OP_ADD || opcode == OP_SUB);
  assign o_enb_acc      = exec && opcode >= OP_LD && opcode <= OP_SUBI;
  assign o_sel_b        = exec && (opcode == OP_ADDI || opcode == OP_SUBI);
  assign o_operation    = exec && (opcode == OP_SUB || opcode == OP_SUBI);
  assign o_sel_a        = !exec ? '0 : opcode == OP_LDI ? NB_SELECTOR_A'(1) :
                          arith ? NB_SELECTOR_A'(2) : '0;
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      IDLE:    state_next = i_start ? FETCH : IDLE;
      FETCH:   state_next = i_instr_valid ? EXECUTE : FETCH;
      EXECUTE: begin
        state_next = opcode == OP_HLT ? HALT : FETCH;
        pc_next    = opcode == OP_HLT ? pc : taken ? operand[NB_ADDR-1:0] : pc + 1'b1;
      end
      HALT: begin
        state_next = i_start ? FETCH : HALT;
        pc_next    = i_start ? '0 : pc;
      end
      default: state_next = IDLE;
    endcase
  end
  // Counter clears only on restart from HALT; a start from IDLE keeps its value.
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state   <= IDLE;
      pc      <= '0;
      opcode  <= '0;
      operand <= '0;
      count   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FETCH && i_instr_valid) begin
        opcode  <= i_opcode;
        operand <= i_operand;
      end
      if (state == HALT && i_start) count <= '0;
      else if (exec && count != '1) count <= count + 1'b1;
    end
endmodule

// File: tb/tb_bip_sequencer.sv
// tb_bip_sequencer: instruction-level reference model drives the memory side and
// queues expected execute results; a negedge monitor compares them against the DUT.
module tb_bip_sequencer;
  localparam int NA = 5, NO = 5, NP = 8, NS = 2, NC = 4;
  localparam int CMAX = (1 << NC) - 1;
  logic i_clock = 0, i_reset = 0, i_start = 0, i_instr_valid = 0, i_acc_zero = 0, i_acc_neg = 0;
  logic [NO-1:0] i_opcode = '0;
  logic [NP-1:0] i_operand = '0;
  logic o_fetch_req, o_sel_b, o_enb_acc, o_operation, o_wr_enb_ram, o_rd_enb_ram, o_program_done;
  logic [NA-1:0] o_address;
  logic [NP-1:0] o_operand;
  logic [NS-1:0] o_sel_a;
  logic [NC-1:0] o_instr_count;
  bip_sequencer #(.NB_ADDR(NA), .NB_OPCODE(NO), .NB_OPERAND(NP), .NB_SELECTOR_A(NS), .NB_COUNT(NC)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .o_fetch_req(o_fetch_req),
    .i_instr_valid(i_instr_valid), .i_opcode(i_opcode), .i_operand(i_operand),
    .i_acc_zero(i_acc_zero), .i_acc_neg(i_acc_neg), .o_address(o_address), .o_operand(o_operand),
    .o_sel_a(o_sel_a), .o_sel_b(o_sel_b), .o_enb_acc(o_enb_acc), .o_operation(o_operation),
    .o_wr_enb_ram(o_wr_enb_ram), .o_rd_enb_ram(o_rd_enb_ram), .o_program_done(o_program_done),
    .o_instr_count(o_instr_count)
  );
  always #5 i_clock = ~i_clock;
  typedef struct {
    logic [1:0] sa;
    logic sb, en, sub, wr, rd;
    logic [NP-1:0] opd;
    logic [NA-1:0] pc;
    logic [NC-1:0] cnt;
    logic done;
  } exp_t;
  exp_t q[$];
  exp_t post;
  bit zq[$];
  int checks = 0, errors = 0;
  logic [NO-1:0] mem_op [0:31];
  logic [NP-1:0] mem_opd[0:31];
  int m_pc = 0, m_cnt = 0;
  bit m_halt = 0;
  bit exec_now = 0, post_pending = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge i_clock) begin
    logic [6:0] act;
    act = {o_sel_a, o_sel_b, o_enb_acc, o_operation, o_wr_enb_ram, o_rd_enb_ram};
    if (!i_reset) begin
      check("reset_outputs", {o_fetch_req, o_address, o_operand, act, o_program_done, o_instr_count}, '0);
      q.delete();
      exec_now = 0;
      post_pending = 0;
    end else begin
      if (post_pending) begin
        check("next_pc", o_address, post.pc);
        check("count", o_instr_count, post.cnt);
        check("done", o_program_done, post.done);
        post_pending = 0;
      end
      if (exec_now) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exec_unexpected: strobes %0h with no instruction issued", act);
        end else begin
          post = q.pop_front();
          check("strobes", act, {post.sa, post.sb, post.en, post.sub, post.wr, post.rd});
          check("operand", o_operand, post.opd);
          post_pending = 1;
        end
      end else check("quiet_strobes", act, '0);
      exec_now = o_fetch_req && i_instr_valid;
    end
  end
  task automatic step();
    @(posedge i_clock);
    #1;
  endtask
  // Architectural effect of one instruction, straight from the opcode table.
  task automatic model(input logic [NO-1:0] op, input logic [NP-1:0] opd, input bit z, input bit ng, output exp_t e);
    bit taken;
    e = '{sa: 0, sb: 0, en: 0, sub: 0, wr: 0, rd: 0, opd: opd, pc: 0, cnt: 0, done: 0};
    case (op)
      1: e.wr = 1;
      2: begin e.rd = 1; e.en = 1; end
      3: begin e.sa = 1; e.en = 1; end
      4, 6: begin e.rd = 1; e.sa = 2; e.en = 1; e.sub = op == 6; end
      5, 7: begin e.sa = 2; e.sb = 1; e.en = 1; e.sub = op == 7; end
      default: ;
    endcase
    taken = op == 8 || (op == 9 && z) || (op == 10 && !z) || (op == 11 && ng);
    m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX;
    if (op == 0) m_halt = 1;
    else m_pc = taken ? int'(opd) % (1 << NA) : (m_pc + 1) % (1 << NA);
    e.pc = NA'(m_pc);
    e.cnt = NC'(m_cnt);
    e.done = m_halt;
  endtask
  task automatic fill_nop();
    for (int i = 0; i < 32; i++) begin
      mem_op[i] = NO'(12);
      mem_opd[i] = NP'($urandom);
    end
  endtask
  task automatic do_reset();
    i_reset = 0;
    i_start = 0;
    i_instr_valid = 0;
    step();
    step();
    m_pc = 0;
    m_cnt = 0;
    m_halt = 0;
    i_reset = 1;
    for (int i = 0; i < 3; i++) begin
      i_instr_valid = 1'($urandom);
      i_opcode = NO'($urandom);
      step();
      check("idle_hold", {o_fetch_req, o_address, o_program_done}, 0);
    end
    i_instr_valid = 0;
  endtask
  // status: 0 halted, 1 instruction budget used up, 2 aborted by reset during STO
  task automatic run_program(input int dmin, input int dmax, input int max_n, input bit abort_ok, output int status);
    int d;
    bit z, ng;
    logic [NO-1:0] op;
    exp_t e;
    if (m_halt) begin
      m_pc = 0;
      m_cnt = 0;
    end
    m_halt = 0;
    i_start = 1;
    step();
    i_start = 0;
    check("fetch_after_start", {o_fetch_req, o_address, o_instr_count}, {1'b1, NA'(m_pc), NC'(m_cnt)});
    status = 1;
    for (int n = 0; n < max_n; n++) begin
      d = dmin + $urandom_range(dmax - dmin);
      for (int k = 0; k <= d; k++) begin
        i_instr_valid = k == d;
        i_opcode = k == d ? mem_op[m_pc] : NO'($urandom);
        i_operand = k == d ? mem_opd[m_pc] : NP'($urandom);
        i_acc_zero = 1'($urandom);
        i_acc_neg = 1'($urandom);
        i_start = $urandom_range(3) == 0;
        check("fetch_wait", {o_fetch_req, o_address}, {1'b1, NA'(m_pc)});
        step();
      end
      op = mem_op[m_pc];
      z = zq.size() > 0 ? zq.pop_front() : 1'($urandom);
      ng = 1'($urandom);
      i_acc_zero = z;
      i_acc_neg = ng;
      i_start = $urandom_range(3) == 0;
      i_instr_valid = 1'($urandom);
      i_opcode = NO'($urandom);
      i_operand = NP'($urandom);
      model(mem_op[m_pc], mem_opd[m_pc], z, ng, e);
      if (abort_ok && op == NO'(1)) begin
        #1;
        check("sto_write", o_wr_enb_ram, 1);
        i_reset = 0;
        i_start = 0;
        i_instr_valid = 0;
        #1;
        check("abort_outputs", {o_wr_enb_ram, o_fetch_req, o_address, o_instr_count}, 0);
        step();
        i_reset = 1;
        m_pc = 0;
        m_cnt = 0;
        m_halt = 0;
        step();
        check("abort_idle", {o_fetch_req, o_program_done}, 0);
        status = 2;
        return;
      end
      q.push_back(e);
      step();
      i_start = 0;
      i_instr_valid = 0;
      if (m_halt) begin
        status = 0;
        break;
      end
    end
  endtask
  initial begin
    int st;
    do_reset();
    fill_nop();
    mem_op[0] = NO'(3); mem_opd[0] = NP'(5);
    mem_op[1] = NO'(5); mem_opd[1] = NP'(3);
    mem_op[2] = NO'(1); mem_opd[2] = NP'(7);
    mem_op[3] = NO'(0); mem_opd[3] = NP'(0);
    run_program(0, 0, 10, 0, st);
    check("prog_halted", st, 0);
    check("prog_final", {o_program_done, o_address, o_instr_count}, {1'b1, 5'd3, 4'd4});
    run_program(3, 3, 10, 0, st);
    check("slow_halted", st, 0);
    check("slow_final", {o_program_done, o_address, o_instr_count}, {1'b1, 5'd3, 4'd4});
    fill_nop();
    mem_op[0] = NO'(9); mem_opd[0] = NP'(20);
    mem_op[20] = NO'(9); mem_opd[20] = NP'(20);
    mem_op[21] = NO'(0);
    zq = '{1'b1, 1'b0};
    run_program(0, 2, 10, 0, st);
    check("branch_final", {o_program_done, o_address, o_instr_count}, {1'b1, 5'd21, 4'd3});
    fill_nop();
    mem_op[0] = NO'(8); mem_opd[0] = NP'(30);
    run_program(0, 1, 24, 0, st);
    check("loop_budget", st, 1);
    check("count_saturate", o_instr_count, 4'd15);
    do_reset();
    fill_nop();
    mem_op[0] = NO'(3);
    mem_op[1] = NO'(1); mem_opd[1] = NP'(7);
    run_program(0, 1, 5, 1, st);
    check("abort_status", st, 2);
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < 32; i++) begin
        mem_op[i] = NO'($urandom_range(15));
        if (mem_op[i] == 0 && $urandom_range(2) != 0) mem_op[i] = NO'(12);
        mem_opd[i] = NP'($urandom);
      end
      run_program(0, 3, 40, 1'($urandom), st);
      if (st == 1) do_reset();
    end
    step();
    step();
    check("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bip_sequencer.md
BIP_SEQUENCER -- requirements
Module: bip_sequencer

Interface
REQ-001 Parameters SHALL be: NB_ADDR, default 11, program-counter and jump-target width.
REQ-002 Parameters SHALL be: NB_OPCODE, default 5, opcode width (at least 4).
REQ-003 Parameters SHALL be: NB_OPERAND, default 11, operand width (at least NB_ADDR).
REQ-004 Parameters SHALL be: NB_SELECTOR_A, default 2, accumulator-mux select width.
REQ-005 Parameters SHALL be: NB_COUNT, default 16, retired-instruction counter width.
REQ-006 Ports SHALL be:
- i_clock  in  1  single clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle start/restart pulse.
- o_fetch_req  out  1  instruction request for the word at o_address.
- i_instr_valid  in  1  instruction memory returns i_opcode/i_operand this cycle.
- i_opcode  in  NB_OPCODE  fetched opcode.
- i_operand  in  NB_OPERAND  fetched operand.
- i_acc_zero  in  1  accumulator == 0.
- i_acc_neg  in  1  accumulator MSB.
- o_address  out  NB_ADDR  program counter.
- o_operand  out  NB_OPERAND  latched operand.
- o_sel_a  out  NB_SELECTOR_A  0 = RAM, 1 = immediate, 2 = ALU.
- o_sel_b  out  1  ALU B: 0 = RAM, 1 = immediate.
- o_enb_acc  out  1  accumulator load.
- o_operation  out  1  0 = add, 1 = subtract.
- o_wr_enb_ram  out  1  data RAM write.
- o_rd_enb_ram  out  1  data RAM read.
- o_program_done  out  1  halted.
- o_instr_count  out  NB_COUNT  retired instructions.

Function
REQ-007 The FSM SHALL have states IDLE, FETCH, EXECUTE and HALT.
REQ-008 IDLE SHALL go to FETCH on i_start; otherwise it SHALL hold.
REQ-009 FETCH SHALL assert o_fetch_req; on i_instr_valid it SHALL latch opcode and operand and go to EXECUTE; otherwise it SHALL hold, with no timeout.
REQ-010 EXECUTE SHALL last exactly one cycle, and control outputs SHALL decode from the latched opcode only in EXECUTE; in every other state they SHALL be 0.
REQ-011 The opcode map SHALL be (others NOP):
- 0 HLT.
- 1 STO: wr_enb_ram.
- 2 LD: rd, sel_a=0, enb_acc.
- 3 LDI: sel_a=1, enb_acc.
- 4 ADD: rd, sel_a=2, sel_b=0, op=0, enb_acc.
- 5 ADDI: sel_a=2, sel_b=1, op=0, enb_acc.
- 6 SUB: same as ADD with op=1.
- 7 SUBI: same as ADDI with op=1.
- 8 JMP.
- 9 BEQ: taken if i_acc_zero.
- 10 BNE: taken if !i_acc_zero.
- 11 BLT: taken if i_acc_neg.
REQ-012 In EXECUTE of a non-HLT instruction, the PC SHALL load operand[NB_ADDR-1:0] if the jump or branch is taken, else PC+1 modulo 2^NB_ADDR (all-ones wraps to 0); the next state SHALL be FETCH.
REQ-013 Branch flags SHALL be sampled in the EXECUTE cycle.
REQ-014 HLT in EXECUTE SHALL go to HALT, and the PC SHALL hold.
REQ-015 HALT SHALL assert o_program_done and hold the PC.
REQ-016 i_start in HALT SHALL clear the PC to 0 and go to FETCH.
REQ-017 i_start in FETCH or EXECUTE SHALL be ignored.
REQ-018 o_instr_count SHALL increment in every EXECUTE cycle, HLT included, and SHALL saturate at all-ones.
REQ-019 o_instr_count SHALL clear on a restart from HALT; a start from IDLE SHALL leave it unchanged.
REQ-020 Timing SHALL be 2 cycles per instruction minimum; o_fetch_req SHALL rise in the cycle after i_start.
REQ-021 i_instr_valid outside FETCH SHALL be ignored.

Reset
REQ-022 While i_reset = 0, asynchronously and regardless of clock, the block SHALL force: state IDLE, PC 0, latched instruction 0, counter 0, every output 0.
REQ-023 Assertion mid-instruction SHALL abort it with no RAM write.
REQ-024 After release, the block SHALL stay in IDLE until i_start.

Verification
REQ-025 Reset then i_start with LDI 5, ADDI 3, STO 7, HLT, valid on first request -> enb_acc in cycles 2 and 4; wr_enb_ram in cycle 6; done from cycle 9; count 4; PC 3.
REQ-026 i_instr_valid delayed 3 cycles on each fetch -> o_fetch_req held, no control strobes while waiting, same results as REQ-025.
REQ-027 BEQ 20 with i_acc_zero=1, then BEQ 20 at 20 with i_acc_zero=0 -> PC 20, then 21.
REQ-028 NB_ADDR=4, NOPs from PC 15 -> PC wraps to 0.
REQ-029 NB_COUNT=3, JMP 0 loop -> count saturates at 7.
REQ-030 i_reset low during EXECUTE of STO -> wr_enb_ram 0 immediately; restart fetches address 0.
REQ-031 i_start in HALT -> PC 0, count 0, fetch next cycle.
